// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline memory stage (master) and the data memory (slave).
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready; the master keeps
// req_we/req_addr/req_wdata stable while req_valid is high and not yet accepted. rsp_valid is a
// one-cycle pulse with no backpressure; rsp_rdata and rsp_err are meaningful only while it is high.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with WAIT_CYCLES wait states and a one-cycle response pulse.
// Optional macro DMEM_BOUNDS_CHECK_EN: out-of-range addresses raise rsp_err instead of aliasing.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [15:0] mem [DEPTH];

  logic          ready;
  logic          accept;
  logic          commit_d;
  logic          c_we;
  logic [15:0]   c_addr;
  logic [15:0]   c_wdata;
  logic [AW-1:0] c_idx;
  logic          in_range;

  assign ready  = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept = bus.req_valid && ready;

  // With zero wait states the incoming request commits on its own accept edge.
  assign commit_d = (accept && (WAIT_CYCLES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign c_we     = (state_q == S_WAIT) ? we_q    : bus.req_we;
  assign c_addr   = (state_q == S_WAIT) ? addr_q  : bus.req_addr;
  assign c_wdata  = (state_q == S_WAIT) ? wdata_q : bus.req_wdata;
  assign c_idx    = c_addr[AW-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, c_addr} < 17'(DEPTH));
`else
  logic unused_addr;
  assign unused_addr = ^c_addr;
  assign in_range    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (commit_d) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !in_range;
        if (!c_we) rsp_rdata_q <= in_range ? mem[c_idx] : 16'h0000;
      end
    end
  end

  // Array is deliberately outside the reset domain so its content survives rst.
  always_ff @(posedge clk) begin
    if (commit_d && c_we && in_range) mem[c_idx] <= c_wdata;
  end

  assign bus.req_ready = ready;
  assign bus.busy      = (state_q == S_WAIT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 3 wait states) against a cycle-level reference model.
module tb_dmem_responder;
  localparam int DEPTH = 256;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk;
  logic rst;
  int   edge_n;
  int   checks;
  int   failures;

  logic        req_valid [3];
  logic        req_we    [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        ready_w   [3];
  logic        valid_w   [3];
  logic [15:0] rdata_w   [3];
  logic        err_w     [3];
  logic        busy_w    [3];
  logic [1:0]  dbg_w     [3];

  dmem_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bus[g].req_valid = req_valid[g];
    assign bus[g].req_we    = req_we[g];
    assign bus[g].req_addr  = req_addr[g];
    assign bus[g].req_wdata = req_wdata[g];
    assign ready_w[g]       = bus[g].req_ready;
    assign valid_w[g]       = bus[g].rsp_valid;
    assign rdata_w[g]       = bus[g].rsp_rdata;
    assign err_w[g]         = bus[g].rsp_err;
    assign busy_w[g]        = bus[g].busy;
  end

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst(rst), .bus(bus[0]), .dbg_state_o(dbg_w[0]));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(bus[1]), .dbg_state_o(dbg_w[1]));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst), .bus(bus[2]), .dbg_state_o(dbg_w[2]));

  // ---------------- clock / edge counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- reference model ----------------
  logic        pend_v     [3];
  int          pend_due   [3];
  logic        pend_we    [3];
  logic [15:0] pend_addr  [3];
  logic [15:0] pend_wdata [3];
  logic [15:0] last_rd    [3];
  logic [15:0] mem_m      [3][DEPTH];
  logic [15:0] exp_q [$];

  function automatic int wait_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 3;
  endfunction

  task automatic chk(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d t=%0t observed=%h expected=%h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic model_step(int k);
    logic exp_v;
    logic exp_b;
    logic oob;
    int   idx;
    if (!rst) begin
      pend_v[k]  = 1'b0;
      last_rd[k] = 16'h0000;
      chk("rst_ready", k, 16'(ready_w[k]), 16'd1);
      chk("rst_valid", k, 16'(valid_w[k]), 16'd0);
      chk("rst_busy",  k, 16'(busy_w[k]),  16'd0);
      chk("rst_err",   k, 16'(err_w[k]),   16'd0);
      chk("rst_rdata", k, rdata_w[k],      16'h0000);
      return;
    end
    exp_v = pend_v[k] && (pend_due[k] == edge_n);
    exp_b = pend_v[k] && (pend_due[k] > edge_n);
    chk("rsp_valid", k, 16'(valid_w[k]), 16'(exp_v));
    chk("busy",      k, 16'(busy_w[k]),  16'(exp_b));
    chk("req_ready", k, 16'(ready_w[k]), 16'(!exp_b));
    if (exp_v) begin
      oob = BC && (pend_addr[k] >= 16'(DEPTH));
      idx = int'(pend_addr[k]) % DEPTH;
      chk("rsp_err", k, 16'(err_w[k]), 16'(oob));
      if (pend_we[k]) begin
        if (!oob) mem_m[k][idx] = pend_wdata[k];
      end else begin
        last_rd[k] = oob ? 16'h0000 : mem_m[k][idx];
        exp_q.push_back(last_rd[k]);
      end
      pend_v[k] = 1'b0;
    end
    if (exp_q.size() != 0) chk("load_data", k, rdata_w[k], exp_q.pop_front());
    chk("rdata_hold", k, rdata_w[k], last_rd[k]);
    // Inputs are stable from here to the next edge, so an accept there is decided now.
    if (req_valid[k] && !exp_b) begin
      pend_v[k]     = 1'b1;
      pend_due[k]   = edge_n + 1 + wait_of(k);
      pend_we[k]    = req_we[k];
      pend_addr[k]  = req_addr[k];
      pend_wdata[k] = req_wdata[k];
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(int k, logic we, logic [15:0] addr, logic [15:0] wdata);
    int n;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_w[k]) break;
    end
    if (n == 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut=%0d observed=no_ready expected=ready_within_50", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int k, int cycles);
    req_valid[k] = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    edge_n   = 0;
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 16'h0000;
      req_wdata[k] = 16'h0000;
      pend_v[k]    = 1'b0;
      pend_due[k]  = 0;
      last_rd[k]   = 16'h0000;
      for (int a = 0; a < DEPTH; a++) mem_m[k][a] = 16'h0000;
    end
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held with random request traffic: outputs must stay at reset values.
    repeat (6) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = 16'($urandom);
        req_wdata[k] = 16'($urandom);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
    rst = 1'b1;
    idle(0, 1);

    // Two wait states: store then load back.
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    idle(0, 4);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    idle(0, 4);

    // Zero wait states: four back-to-back accesses.
    issue(1, 1'b1, 16'h0001, 16'h0001);
    issue(1, 1'b1, 16'h0002, 16'h0002);
    issue(1, 1'b0, 16'h0001, 16'h0000);
    issue(1, 1'b0, 16'h0002, 16'h0000);
    idle(1, 3);

    // Three wait states with req_valid held across two requests.
    issue(2, 1'b1, 16'h0030, 16'h7E57);
    issue(2, 1'b0, 16'h0030, 16'h0000);
    idle(2, 6);

    // Reset while a store sits in its wait states: no write, no response.
    issue(0, 1'b1, 16'h0020, 16'h5555);
    idle(0, 4);
    issue(0, 1'b1, 16'h0020, 16'h1234);
    req_valid[0] = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(0, 1);
    issue(0, 1'b0, 16'h0020, 16'h0000);
    idle(0, 4);

    // Out-of-range store: error with bounds check, alias to word 0 without.
    issue(0, 1'b1, 16'h0100, 16'hAAAA);
    idle(0, 4);
    issue(0, 1'b0, 16'h0000, 16'h0000);
    idle(0, 4);

    // Randomized traffic on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        int gap;
        logic [15:0] addr;
        gap  = $urandom_range(0, 2);
        addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
        issue(k, 1'($urandom_range(0, 1)), addr, 16'($urandom));
        if (gap > 0) idle(k, gap);
      end
      idle(k, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
